// File: rtl/posit_job_bridge_pkg.sv
// ============================================================================
// posit_job_bridge_pkg : register map, STATUS bit positions and opcodes
// Rev 1.0
// ============================================================================
`default_nettype none

package posit_job_bridge_pkg;

  localparam int REG_OPA    = 0;
  localparam int REG_OPB    = 1;
  localparam int REG_CMD    = 2;
  localparam int REG_STATUS = 3;
  localparam int REG_RESULT = 4;
  localparam int REG_IRQ_EN = 5;

  localparam int ST_JOB_FULL     = 0;
  localparam int ST_JOB_EMPTY    = 1;
  localparam int ST_RES_EMPTY    = 2;
  localparam int ST_RES_FULL     = 3;
  localparam int ST_CMD_OVF      = 4;
  localparam int ST_RES_UDF      = 5;
  localparam int ST_INFLIGHT_LSB = 8;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_DIV = 2'd3
  } op_e;

endpackage

`default_nettype wire

// File: rtl/posit_job_bridge_if.sv
// ============================================================================
// posit_job_bridge_if : Avalon-MM slave bus plus engine job/result handshakes
// Rev 1.0
// ============================================================================
`default_nettype none

interface posit_job_bridge_if #(
  parameter int DATA_W = 32,
  parameter int OP_W   = 2,
  parameter int ADDR_W = 3
);
  logic [ADDR_W-1:0] avs_address;
  logic              avs_write;
  logic [31:0]       avs_writedata;
  logic              avs_read;
  logic [31:0]       avs_readdata;
  logic              irq;
  logic              eng_valid;
  logic              eng_ready;
  logic [DATA_W-1:0] eng_a;
  logic [DATA_W-1:0] eng_b;
  logic [OP_W-1:0]   eng_op;
  logic              res_valid;
  logic              res_ready;
  logic [DATA_W-1:0] res_data;

  modport slave (
    input  avs_address, avs_write, avs_writedata, avs_read,
    output avs_readdata, irq,
    output eng_valid, eng_a, eng_b, eng_op,
    input  eng_ready,
    input  res_valid, res_data,
    output res_ready
  );

  modport master (
    output avs_address, avs_write, avs_writedata, avs_read,
    input  avs_readdata, irq,
    input  eng_valid, eng_a, eng_b, eng_op,
    output eng_ready,
    output res_valid, res_data,
    input  res_ready
  );

endinterface

`default_nettype wire

// File: rtl/bridge_sync_fifo.sv
// ============================================================================
// bridge_sync_fifo : single-clock FIFO, push into a full FIFO allowed when popped
// Rev 1.0
// ============================================================================
`default_nettype none

module bridge_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [AW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == CNT_MAX);
  assign empty   = (cnt == '0);
  assign count   = cnt;
  assign rdata   = mem[rptr];
  assign do_pop  = pop && !empty;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wptr] <= wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) begin
        wptr <= wptr + PTR_ONE;
      end
      if (do_pop) begin
        rptr <= rptr + PTR_ONE;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/posit_job_bridge.sv
// ============================================================================
// posit_job_bridge : Avalon-MM command/result bridge to a posit/FP engine
// Rev 1.0
// ============================================================================
`default_nettype none

module posit_job_bridge
  import posit_job_bridge_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int OP_W   = 2,
  parameter int ADDR_W = 3
) (
  input logic                clk,
  input logic                reset,
  posit_job_bridge_if.slave  bus
);

  localparam int CW    = $clog2(DEPTH) + 1;
  localparam int JOB_W = 2 * DATA_W + OP_W;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW:0]   CREDITS = (CW+1)'(DEPTH);

  logic [DATA_W-1:0] opa;
  logic [DATA_W-1:0] opb;
  logic              irq_en;
  logic              cmd_ovf;
  logic              res_udf;
  logic [CW-1:0]     inflight;
  logic [31:0]       rdata_reg;

  logic wr_opa, wr_opb, wr_cmd, wr_status, wr_irq_en, rd_result;

  assign wr_opa    = bus.avs_write && (bus.avs_address == ADDR_W'(REG_OPA));
  assign wr_opb    = bus.avs_write && (bus.avs_address == ADDR_W'(REG_OPB));
  assign wr_cmd    = bus.avs_write && (bus.avs_address == ADDR_W'(REG_CMD));
  assign wr_status = bus.avs_write && (bus.avs_address == ADDR_W'(REG_STATUS));
  assign wr_irq_en = bus.avs_write && (bus.avs_address == ADDR_W'(REG_IRQ_EN));
  assign rd_result = bus.avs_read  && (bus.avs_address == ADDR_W'(REG_RESULT));

  logic [JOB_W-1:0] job_wdata;
  logic [JOB_W-1:0] job_head;
  logic             job_full, job_empty;
  logic [CW-1:0]    job_count;
  logic             issue;

  assign job_wdata = {opa, opb, bus.avs_writedata[OP_W-1:0]};

  bridge_sync_fifo #(
    .WIDTH (JOB_W),
    .DEPTH (DEPTH)
  ) u_job_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (wr_cmd),
    .pop   (issue),
    .wdata (job_wdata),
    .rdata (job_head),
    .full  (job_full),
    .empty (job_empty),
    .count (job_count)
  );

  logic [DATA_W-1:0] res_head;
  logic              res_full, res_empty;
  logic [CW-1:0]     res_count;
  logic              retire;
  logic              res_pop;

  assign retire  = bus.res_valid && !res_full;
  assign res_pop = rd_result && !res_empty;

  bridge_sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_res_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (retire),
    .pop   (res_pop),
    .wdata (bus.res_data),
    .rdata (res_head),
    .full  (res_full),
    .empty (res_empty),
    .count (res_count)
  );

  // Only issue while every outstanding job is guaranteed a result slot
  logic [CW:0] committed;
  logic        has_credit;

  assign committed  = {1'b0, inflight} + {1'b0, res_count};
  assign has_credit = (committed < CREDITS);

  assign bus.eng_valid = !job_empty && has_credit;
  assign bus.eng_a     = job_head[JOB_W-1 -: DATA_W];
  assign bus.eng_b     = job_head[OP_W +: DATA_W];
  assign bus.eng_op    = job_head[OP_W-1:0];
  assign issue         = bus.eng_valid && bus.eng_ready;
  assign bus.res_ready = !res_full;
  assign bus.irq       = irq_en && !res_empty;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      opa      <= '0;
      opb      <= '0;
      irq_en   <= 1'b0;
      cmd_ovf  <= 1'b0;
      res_udf  <= 1'b0;
      inflight <= '0;
    end else begin
      if (wr_opa)    opa    <= DATA_W'(bus.avs_writedata);
      if (wr_opb)    opb    <= DATA_W'(bus.avs_writedata);
      if (wr_irq_en) irq_en <= bus.avs_writedata[0];

      if (wr_cmd && job_full && !issue) begin
        cmd_ovf <= 1'b1;
      end else if (wr_status && bus.avs_writedata[ST_CMD_OVF]) begin
        cmd_ovf <= 1'b0;
      end

      if (rd_result && res_empty) begin
        res_udf <= 1'b1;
      end else if (wr_status && bus.avs_writedata[ST_RES_UDF]) begin
        res_udf <= 1'b0;
      end

      unique case ({issue, retire})
        2'b10:   inflight <= inflight + CNT_ONE;
        2'b01:   inflight <= inflight - CNT_ONE;
        default: inflight <= inflight;
      endcase
    end
  end

  logic [31:0] status;
  logic [31:0] read_mux;

  always_comb begin
    status                              = '0;
    status[ST_JOB_FULL]                 = job_full;
    status[ST_JOB_EMPTY]                = job_empty;
    status[ST_RES_EMPTY]                = res_empty;
    status[ST_RES_FULL]                 = res_full;
    status[ST_CMD_OVF]                  = cmd_ovf;
    status[ST_RES_UDF]                  = res_udf;
    status[ST_INFLIGHT_LSB +: CW]       = inflight;
  end

  always_comb begin
    read_mux = '0;
    case (bus.avs_address)
      ADDR_W'(REG_OPA):    read_mux = 32'(opa);
      ADDR_W'(REG_OPB):    read_mux = 32'(opb);
      ADDR_W'(REG_STATUS): read_mux = status;
      ADDR_W'(REG_RESULT): read_mux = res_empty ? 32'd0 : 32'(res_head);
      ADDR_W'(REG_IRQ_EN): read_mux = {31'd0, irq_en};
      default:             read_mux = '0;
    endcase
  end

  // Read data holds its last value between reads
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_reg <= '0;
    end else if (bus.avs_read) begin
      rdata_reg <= read_mux;
    end
  end

  assign bus.avs_readdata = rdata_reg;

endmodule

`default_nettype wire

// File: tb/tb_posit_job_bridge.sv
// ============================================================================
// tb_posit_job_bridge : directed table-driven bench with a fixed-latency engine
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_posit_job_bridge;
  import posit_job_bridge_pkg::*;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int OP_W   = 2;
  localparam int ADDR_W = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  posit_job_bridge_if #(.DATA_W(DATA_W), .OP_W(OP_W), .ADDR_W(ADDR_W)) bus ();

  posit_job_bridge #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .OP_W   (OP_W),
    .ADDR_W (ADDR_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
  } job_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } pend_t;

  function automatic logic [31:0] model(input job_t j);
    if (j.a == 32'h4000_0000 && j.b == 32'h4000_0000 && j.op == 2'd0)
      return 32'h4800_0000;
    return j.a ^ {j.b[15:0], j.b[31:16]} ^ {30'd0, j.op};
  endfunction

  // Engine model: accepts jobs when told, answers in order 3 cycles later
  pend_t       pend[$];
  job_t        issued[$];
  job_t        sent[$];
  int          cyc = 0;
  bit          man_mode = 1'b0;
  logic        eng_res_valid = 1'b0;
  logic [31:0] eng_res_data  = '0;
  logic        man_valid     = 1'b0;
  logic [31:0] man_data      = '0;

  assign bus.res_valid = man_mode ? man_valid : eng_res_valid;
  assign bus.res_data  = man_mode ? man_data  : eng_res_data;

  always @(posedge clk) begin : engine
    bit   hs_i;
    bit   hs_r;
    job_t j;
    cyc++;
    hs_i = bus.eng_valid && bus.eng_ready;
    hs_r = bus.res_valid && bus.res_ready;
    j    = {bus.eng_a, bus.eng_b, bus.eng_op};
    #1;
    if (reset) begin
      pend.delete();
    end else begin
      if (hs_r && !man_mode && pend.size() > 0) void'(pend.pop_front());
      if (hs_i) begin
        issued.push_back(j);
        pend.push_back('{model(j), cyc + 3});
      end
    end
    eng_res_valid = 1'b0;
    eng_res_data  = '0;
    if (pend.size() > 0) begin
      if (pend[0].due <= cyc) begin
        eng_res_valid = 1'b1;
        eng_res_data  = pend[0].data;
      end
    end
  end

  task automatic wr(input int addr, input logic [31:0] d);
    @(negedge clk);
    bus.avs_address   = ADDR_W'(addr);
    bus.avs_writedata = d;
    bus.avs_write     = 1'b1;
    @(posedge clk);
    #1;
    bus.avs_write = 1'b0;
  endtask

  task automatic rd(input int addr, output logic [31:0] d);
    @(negedge clk);
    bus.avs_address = ADDR_W'(addr);
    bus.avs_read    = 1'b1;
    @(posedge clk);
    #1;
    bus.avs_read = 1'b0;
    d = bus.avs_readdata;
  endtask

  task automatic rd_chk(input string name, input int addr, input logic [31:0] exp);
    logic [31:0] d;
    rd(addr, d);
    check(name, d, exp);
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input bit accept);
    wr(REG_OPA, a);
    wr(REG_OPB, b);
    wr(REG_CMD, {30'd0, op});
    if (accept) sent.push_back({a, b, op});
  endtask

  task automatic check_issued(input string name);
    check({name, "_count"}, issued.size(), sent.size());
    for (int i = 0; i < sent.size(); i++) begin
      if (i < issued.size()) begin
        check({name, "_a"},  issued[i].a, sent[i].a);
        check({name, "_b"},  issued[i].b, sent[i].b);
        check({name, "_op"}, {30'd0, issued[i].op}, {30'd0, sent[i].op});
      end
    end
  endtask

  task automatic read_results(input string name, input int first, input int n);
    for (int i = first; i < first + n; i++) begin
      rd_chk(name, REG_RESULT, model(sent[i]));
    end
  endtask

  typedef struct {
    bit          is_wr;
    int          addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[14];

  initial begin
    logic [31:0] d;

    bus.avs_address   = '0;
    bus.avs_write     = 1'b0;
    bus.avs_writedata = '0;
    bus.avs_read      = 1'b0;
    bus.eng_ready     = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    check("rst_eng_valid", {31'd0, bus.eng_valid}, 32'd0);
    check("rst_res_ready", {31'd0, bus.res_ready}, 32'd1);
    check("rst_irq",       {31'd0, bus.irq},       32'd0);
    check("rst_readdata",  bus.avs_readdata,       32'd0);

    vt[0]  = '{1'b0, REG_OPA,    32'h0,          32'h0};
    vt[1]  = '{1'b0, REG_OPB,    32'h0,          32'h0};
    vt[2]  = '{1'b0, REG_STATUS, 32'h0,          32'h6};
    vt[3]  = '{1'b0, REG_IRQ_EN, 32'h0,          32'h0};
    vt[4]  = '{1'b1, REG_OPA,    32'hDEAD_BEEF,  32'h0};
    vt[5]  = '{1'b0, REG_OPA,    32'h0,          32'hDEAD_BEEF};
    vt[6]  = '{1'b1, REG_OPB,    32'h1234_5678,  32'h0};
    vt[7]  = '{1'b0, REG_OPB,    32'h0,          32'h1234_5678};
    vt[8]  = '{1'b0, REG_CMD,    32'h0,          32'h0};
    vt[9]  = '{1'b1, REG_IRQ_EN, 32'hFFFF_FFFF,  32'h0};
    vt[10] = '{1'b0, REG_IRQ_EN, 32'h0,          32'h1};
    vt[11] = '{1'b1, REG_IRQ_EN, 32'h0,          32'h0};
    vt[12] = '{1'b1, 6,          32'h0000_AAAA,  32'h0};
    vt[13] = '{1'b0, 6,          32'h0,          32'h0};

    for (int i = 0; i < 14; i++) begin
      if (vt[i].is_wr) wr(vt[i].addr, vt[i].data);
      else             rd_chk($sformatf("regvec%0d", i), vt[i].addr, vt[i].exp);
    end
    rd_chk("reg7_zero", 7, 32'h0);

    // 1: single job round trip
    issued.delete(); sent.delete();
    bus.eng_ready = 1'b1;
    send_cmd(32'h4000_0000, 32'h4000_0000, 2'd0, 1'b1);
    repeat (8) @(posedge clk);
    rd_chk("t1_status_full", REG_STATUS, 32'h0000_0002);
    check_issued("t1_issue");
    rd_chk("t1_result", REG_RESULT, 32'h4800_0000);
    rd_chk("t1_status_empty", REG_STATUS, 32'h0000_0006);

    // 2: job FIFO overflow while engine stalled
    issued.delete(); sent.delete();
    bus.eng_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      send_cmd(32'h100 + i, 32'h200 + i, 2'(i), i < 4);
    rd_chk("t2_status_ovf", REG_STATUS, 32'h0000_0015);
    check("t2_valid_held", {31'd0, bus.eng_valid}, 32'd1);
    check("t2_a_held", bus.eng_a, 32'h100);
    wr(REG_STATUS, 32'h10);
    rd_chk("t2_status_w1c", REG_STATUS, 32'h0000_0005);
    bus.eng_ready = 1'b1;
    repeat (14) @(posedge clk);
    check_issued("t2_issue");
    rd_chk("t2_status_resfull", REG_STATUS, 32'h0000_000A);
    read_results("t2_result", 0, 4);

    // 3: credit stall with no reads, then drain resumes issue
    issued.delete(); sent.delete();
    for (int i = 0; i < 10; i++)
      send_cmd(32'h1000 + i, 32'h55, 2'(i), i < 8);
    repeat (10) @(posedge clk);
    rd_chk("t3_status_stall", REG_STATUS, 32'h0000_0019);
    check("t3_issued_stall", issued.size(), 32'd4);
    check("t3_res_ready", {31'd0, bus.res_ready}, 32'd0);
    read_results("t3_result_a", 0, 4);
    repeat (16) @(posedge clk);
    read_results("t3_result_b", 4, 4);
    check_issued("t3_issue");
    rd_chk("t3_status_end", REG_STATUS, 32'h0000_0016);
    wr(REG_STATUS, 32'h10);
    rd_chk("t3_status_clr", REG_STATUS, 32'h0000_0006);

    // 4: underflow read and IRQ level
    issued.delete(); sent.delete();
    rd_chk("t4_udf_data", REG_RESULT, 32'h0);
    rd_chk("t4_udf_status", REG_STATUS, 32'h0000_0026);
    wr(REG_STATUS, 32'h20);
    rd_chk("t4_udf_clr", REG_STATUS, 32'h0000_0006);
    wr(REG_IRQ_EN, 32'h1);
    check("t4_irq_idle", {31'd0, bus.irq}, 32'd0);
    send_cmd(32'h7, 32'h9, 2'd2, 1'b1);
    repeat (8) @(posedge clk);
    check("t4_irq_set", {31'd0, bus.irq}, 32'd1);
    @(negedge clk);
    bus.avs_address = ADDR_W'(REG_RESULT);
    bus.avs_read    = 1'b1;
    @(posedge clk);
    #1;
    bus.avs_read = 1'b0;
    check("t4_irq_result", bus.avs_readdata, model(sent[0]));
    check("t4_irq_drop", {31'd0, bus.irq}, 32'd0);

    // 4b: result push and RESULT read collide on an empty FIFO
    man_mode = 1'b1;
    send_cmd(32'h11, 32'h22, 2'd1, 1'b1);
    repeat (3) @(posedge clk);
    rd_chk("t4b_inflight", REG_STATUS, 32'h0000_0106);
    @(negedge clk);
    bus.avs_address = ADDR_W'(REG_RESULT);
    bus.avs_read    = 1'b1;
    man_valid       = 1'b1;
    man_data        = 32'hCAFE_F00D;
    @(posedge clk);
    #1;
    bus.avs_read = 1'b0;
    man_valid    = 1'b0;
    check("t4b_collide_data", bus.avs_readdata, 32'h0);
    rd_chk("t4b_status", REG_STATUS, 32'h0000_0022);
    check("t4b_irq", {31'd0, bus.irq}, 32'd1);
    rd_chk("t4b_result", REG_RESULT, 32'hCAFE_F00D);
    wr(REG_STATUS, 32'h20);

    // 5: asynchronous reset mid-burst
    send_cmd(32'h31, 32'h32, 2'd3, 1'b1);
    repeat (2) @(posedge clk);
    bus.eng_ready = 1'b0;
    send_cmd(32'h41, 32'h42, 2'd0, 1'b1);
    send_cmd(32'h51, 32'h52, 2'd1, 1'b1);
    rd_chk("t5_status_pre", REG_STATUS, 32'h0000_0104);
    check("t5_valid_pre", {31'd0, bus.eng_valid}, 32'd1);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("t5_async_valid", {31'd0, bus.eng_valid}, 32'd0);
    check("t5_async_ready", {31'd0, bus.res_ready}, 32'd1);
    check("t5_async_irq", {31'd0, bus.irq}, 32'd0);
    check("t5_async_rdata", bus.avs_readdata, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset    = 1'b0;
    man_mode = 1'b0;
    rd_chk("t5_status_post", REG_STATUS, 32'h0000_0006);
    rd_chk("t5_irq_en_post", REG_IRQ_EN, 32'h0);
    rd_chk("t5_opa_post", REG_OPA, 32'h0);

    // 6: push into a full job FIFO while the engine pops the same cycle
    issued.delete(); sent.delete();
    for (int i = 0; i < 4; i++)
      send_cmd(32'h3000 + i, 32'h4000 + i, 2'(i), 1'b1);
    rd_chk("t6_status_full", REG_STATUS, 32'h0000_0005);
    wr(REG_OPA, 32'h3004);
    wr(REG_OPB, 32'h4004);
    @(negedge clk);
    bus.avs_address   = ADDR_W'(REG_CMD);
    bus.avs_writedata = 32'h0;
    bus.avs_write     = 1'b1;
    bus.eng_ready     = 1'b1;
    @(posedge clk);
    #1;
    bus.avs_write = 1'b0;
    sent.push_back({32'h3004, 32'h4004, 2'd0});
    rd_chk("t6_status_same", REG_STATUS, 32'h0000_0105);
    repeat (16) @(posedge clk);
    read_results("t6_result_a", 0, 4);
    repeat (10) @(posedge clk);
    read_results("t6_result_b", 4, 1);
    check_issued("t6_issue");
    rd_chk("t6_status_end", REG_STATUS, 32'h0000_0006);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
